// File: rtl/pixel_span_coalescer.sv
// Merges horizontally contiguous pixels of one row into spans of up to MAX_SPAN pixels.
// Define PIXEL_COALESCER_TIMEOUT_EN to flush a partial span after TIMEOUT idle cycles.
module pixel_span_coalescer #(
  parameter int unsigned MAX_SPAN = 8,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [63:0]            pixel_data,
  input  logic                   pixel_data_valid,
  output logic                   pixel_ready,
  input  logic                   flush,
  output logic                   span_valid,
  input  logic                   span_ready,
  output logic [11:0]            span_x,
  output logic [11:0]            span_y,
  output logic [4:0]             span_length,
  output logic [32*MAX_SPAN-1:0] span_data,
  output logic                   idle
);

  localparam int unsigned DATA_W = 32 * MAX_SPAN;
  localparam int unsigned LEN_W  = 5;
  localparam int unsigned CNT_W  = 8;
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_SPAN);
  localparam logic [LEN_W-1:0] LEN_LAST = LEN_W'(MAX_SPAN - 1);

  // Pixel fields; the zero pad nibbles carry nothing.
  logic [11:0] x_in;
  logic [11:0] y_in;
  logic [31:0] argb_in;
  logic        unused_pad;

  assign x_in       = pixel_data[59:48];
  assign y_in       = pixel_data[43:32];
  assign argb_in    = pixel_data[31:0];
  assign unused_pad = ^{pixel_data[63:60], pixel_data[47:44]};

  logic              acc_valid;
  logic [11:0]       acc_x;
  logic [11:0]       acc_y;
  logic [LEN_W-1:0]  acc_len;
  logic [DATA_W-1:0] acc_data;

  logic [12:0]       acc_end;
  logic              adjacent;
  logic              room;
  logic              out_free;
  logic              accept;
  logic              append;
  logic              start_new;
  logic              completes;
  logic              timeout_hit;
  logic              drain;
  logic              xfer_acc;
  logic              load_out;
  logic [DATA_W-1:0] merged_data;

  // Carry out of x + len is kept so a span never wraps from x=4095 to x=0.
  assign acc_end   = {1'b0, acc_x} + 13'(acc_len);
  assign adjacent  = acc_valid && (y_in == acc_y) && (acc_end == {1'b0, x_in});
  assign room      = acc_len < LEN_MAX;
  assign out_free  = !span_valid || span_ready;

  assign pixel_ready = !flush && (!acc_valid || out_free || (adjacent && room));
  assign accept      = pixel_data_valid && pixel_ready;
  assign append      = accept && adjacent && room;
  assign start_new   = accept && !append;

  // The pixel that fills a span goes straight to the output when it is free.
  assign completes = append && (acc_len == LEN_LAST) && out_free;

  assign drain    = !accept && acc_valid && out_free &&
                    ((acc_len == LEN_MAX) || flush || timeout_hit);
  assign xfer_acc = (start_new && acc_valid) || drain;
  assign load_out = xfer_acc || completes;

  assign idle = !acc_valid && !span_valid;

  // Accumulator contents with the incoming colour placed at slot acc_len.
  always_comb begin
    merged_data = acc_data;
    for (int unsigned i = 0; i < MAX_SPAN; i++) begin
      if (LEN_W'(i) == acc_len) begin
        merged_data[32*i +: 32] = argb_in;
      end
    end
  end

`ifdef PIXEL_COALESCER_TIMEOUT_EN
  logic [CNT_W-1:0] idle_cnt;

  assign timeout_hit = (idle_cnt == CNT_W'(TIMEOUT));

  // Counts cycles a partial span waits without new pixels; saturates at TIMEOUT.
  always_ff @(posedge clock) begin
    if (reset) begin
      idle_cnt <= '0;
    end else if (accept || load_out) begin
      idle_cnt <= '0;
    end else if (acc_valid && !timeout_hit) begin
      idle_cnt <= idle_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_timeout;

  assign timeout_hit    = 1'b0;
  assign unused_timeout = ^CNT_W'(TIMEOUT);
`endif

  // Accumulator: open span being built from the pixel stream.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_valid <= 1'b0;
      acc_x     <= '0;
      acc_y     <= '0;
      acc_len   <= '0;
      acc_data  <= '0;
    end else if (start_new) begin
      acc_valid <= 1'b1;
      acc_x     <= x_in;
      acc_y     <= y_in;
      acc_len   <= LEN_W'(1);
      acc_data  <= DATA_W'(argb_in);
    end else if (completes || drain) begin
      acc_valid <= 1'b0;
      acc_len   <= '0;
      acc_data  <= '0;
    end else if (append) begin
      acc_len   <= acc_len + LEN_W'(1);
      acc_data  <= merged_data;
    end
  end

  // Output span register; held while the consumer stalls.
  always_ff @(posedge clock) begin
    if (reset) begin
      span_valid  <= 1'b0;
      span_x      <= '0;
      span_y      <= '0;
      span_length <= '0;
      span_data   <= '0;
    end else if (load_out) begin
      span_valid  <= 1'b1;
      span_x      <= acc_x;
      span_y      <= acc_y;
      span_length <= completes ? LEN_MAX : acc_len;
      span_data   <= completes ? merged_data : acc_data;
    end else if (span_ready) begin
      span_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pixel_span_coalescer.sv
// Self-checking bench for pixel_span_coalescer: vector table, directed corner cases
// and a randomized stream checked against a span-list reference model.
module tb_pixel_span_coalescer;

  localparam int MAX_SPAN = 8;
  localparam int TIMEOUT  = 16;
  localparam int DW       = 32 * MAX_SPAN;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [63:0]   pixel_data = '0;
  logic          pixel_data_valid = 1'b0;
  logic          pixel_ready;
  logic          flush = 1'b0;
  logic          span_valid;
  logic          span_ready = 1'b0;
  logic [11:0]   span_x;
  logic [11:0]   span_y;
  logic [4:0]    span_length;
  logic [DW-1:0] span_data;
  logic          idle;

  pixel_span_coalescer #(.MAX_SPAN(MAX_SPAN), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .pixel_data(pixel_data),
    .pixel_data_valid(pixel_data_valid), .pixel_ready(pixel_ready), .flush(flush),
    .span_valid(span_valid), .span_ready(span_ready), .span_x(span_x), .span_y(span_y),
    .span_length(span_length), .span_data(span_data), .idle(idle)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: the accepted pixel stream cut into spans.
  typedef struct {
    int            x;
    int            y;
    int            len;
    logic [DW-1:0] d;
  } span_t;

  span_t         exp_q[$];
  int            cur_x = 0, cur_y = 0, cur_len = 0;
  logic [DW-1:0] cur_data = '0;

  task automatic close_cur();
    span_t s;
    if (cur_len > 0) begin
      s.x = cur_x; s.y = cur_y; s.len = cur_len; s.d = cur_data;
      exp_q.push_back(s);
      cur_len  = 0;
      cur_data = '0;
    end
  endtask

  task automatic model_add(input int x, input int y, input logic [31:0] c);
    if (!(cur_len > 0 && y == cur_y && cur_x + cur_len == x && cur_len < MAX_SPAN)) begin
      close_cur();
      cur_x = x;
      cur_y = y;
    end
    cur_data[32*cur_len +: 32] = c;
    cur_len++;
    if (cur_len == MAX_SPAN) close_cur();
  endtask

  // Stream monitor: feeds the model and scores every span handshake.
  logic          mon_en = 1'b0;
  logic          prev_stall = 1'b0;
  logic [11:0]   hold_x, hold_y;
  logic [4:0]    hold_len;
  logic [DW-1:0] hold_data;

  always @(negedge clock) begin
    if (mon_en) begin
      if (pixel_data_valid && pixel_ready)
        model_add(int'(pixel_data[59:48]), int'(pixel_data[43:32]), pixel_data[31:0]);
      if (flush) close_cur();
      if (prev_stall)
        chk("stall_hold", {span_valid, span_x, span_y, span_length, (span_data == hold_data)},
            {1'b1, hold_x, hold_y, hold_len, 1'b1});
      if (span_valid && span_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_span: got x=%0d len=%0d expected none", span_x, span_length);
        end else begin
          span_t e;
          e = exp_q.pop_front();
          chk("span_x", span_x, 64'(e.x));
          chk("span_y", span_y, 64'(e.y));
          chk("span_length", span_length, 64'(e.len));
          chk_data("span_data", span_data, e.d);
        end
      end
      prev_stall = span_valid && !span_ready;
      hold_x = span_x; hold_y = span_y; hold_len = span_length; hold_data = span_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  logic rand_ready = 1'b0;
  always @(posedge clock) begin
    #1;
    if (rand_ready) span_ready = ($urandom % 4) != 0;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input int x, input int y, input logic [31:0] c);
    bit done;
    done = 1'b0;
    pixel_data       = {4'b0, 12'(x), 4'b0, 12'(y), c};
    pixel_data_valid = 1'b1;
    for (int t = 0; t < 500 && !done; t++) begin
      @(negedge clock);
      done = pixel_ready;
      tick();
    end
    pixel_data_valid = 1'b0;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: pixel x=%0d y=%0d got not accepted expected accepted", x, y);
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    flush = 1'b1;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clock);
      ok = idle;
      tick();
    end
    flush = 1'b0;
    chk("drain_idle", ok, 1);
  endtask

  typedef struct {
    logic          v;
    logic [11:0]   x;
    logic [11:0]   y;
    logic [31:0]   c;
    logic          fl;
    logic          e_pr;
    logic          e_sv;
    logic          e_idle;
    logic [11:0]   e_x;
    logic [11:0]   e_y;
    logic [4:0]    e_len;
    logic [DW-1:0] e_data;
  } vec_t;

  function automatic vec_t mk(bit v, int x, int y, logic [31:0] c, bit fl, bit pr, bit sv,
                              bit idl, int ex, int ey, int el, logic [DW-1:0] ed);
    vec_t r;
    r.v = v; r.x = 12'(x); r.y = 12'(y); r.c = c; r.fl = fl;
    r.e_pr = pr; r.e_sv = sv; r.e_idle = idl;
    r.e_x = 12'(ex); r.e_y = 12'(ey); r.e_len = 5'(el); r.e_data = ed;
    return r;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1);
  end

  initial begin
    vec_t          tbl[$];
    logic [DW-1:0] d_a, d_b, d_40, d_c2, d_c0, d_f, z;
    bit            seen;
    int            px, py;

    z = '0;
    d_a = '0;
    for (int i = 0; i < 8; i++) d_a[32*i +: 32] = 32'hA5A5_0000 + 32'(i);
    d_b = '0;
    for (int i = 0; i < 3; i++) d_b[32*i +: 32] = 32'hB000_0010 + 32'(i);
    d_40 = DW'(32'hB000_0040);
    d_c2 = DW'({32'hC000_0FFF, 32'hC000_0FFE});
    d_c0 = DW'(32'hC000_0000);
    d_f = '0;
    for (int i = 0; i < 5; i++) d_f[32*i +: 32] = 32'hF000_0000 + 32'(i);

    // Contiguous row of 8, a break, then the x=4095 -> 0 non-wrap case.
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1, 100 + i, 5, 32'hA5A5_0000 + 32'(i), 0, 1, 0, (i == 0), 0, 0, 0, z));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 100, 5, 8, d_a));
    tbl.push_back(mk(1, 10, 3, 32'hB000_0010, 0, 1, 0, 1, 0, 0, 0, z));
    tbl.push_back(mk(1, 11, 3, 32'hB000_0011, 0, 1, 0, 0, 0, 0, 0, z));
    tbl.push_back(mk(1, 12, 3, 32'hB000_0012, 0, 1, 0, 0, 0, 0, 0, z));
    tbl.push_back(mk(1, 40, 3, 32'hB000_0040, 0, 1, 0, 0, 0, 0, 0, z));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 10, 3, 3, d_b));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, z));
    tbl.push_back(mk(1, 4094, 7, 32'hC000_0FFE, 0, 1, 1, 0, 40, 3, 1, d_40));
    tbl.push_back(mk(1, 4095, 7, 32'hC000_0FFF, 0, 1, 0, 0, 0, 0, 0, z));
    tbl.push_back(mk(1, 0, 7, 32'hC000_0000, 0, 1, 0, 0, 0, 0, 0, z));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 4094, 7, 2, d_c2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 7, 1, d_c0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, z));

    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    span_ready = 1'b1;
    @(negedge clock);
    chk("reset_span_valid", span_valid, 0);
    chk("reset_span_fields", {span_x, span_y, span_length}, 0);
    chk_data("reset_span_data", span_data, z);
    chk("reset_idle", idle, 1);
    chk("reset_pixel_ready", pixel_ready, 1);

    foreach (tbl[i]) begin
      tick();
      pixel_data_valid = tbl[i].v;
      pixel_data = {4'b0, tbl[i].x, 4'b0, tbl[i].y, tbl[i].c};
      flush = tbl[i].fl;
      @(negedge clock);
      chk($sformatf("t%0d_pixel_ready", i), pixel_ready, tbl[i].e_pr);
      chk($sformatf("t%0d_span_valid", i), span_valid, tbl[i].e_sv);
      chk($sformatf("t%0d_idle", i), idle, tbl[i].e_idle);
      if (tbl[i].e_sv) begin
        chk($sformatf("t%0d_span_xyl", i), {span_x, span_y, span_length},
            {tbl[i].e_x, tbl[i].e_y, tbl[i].e_len});
        chk_data($sformatf("t%0d_span_data", i), span_data, tbl[i].e_data);
      end
    end
    tick();
    pixel_data_valid = 1'b0;
    flush = 1'b0;

    // Stalled consumer with scattered pixels: the second break must back-pressure.
    mon_en = 1'b1;
    span_ready = 1'b0;
    send(50, 11, 32'hD000_0000);
    send(53, 11, 32'hD000_0001);
    pixel_data = {4'b0, 12'(56), 4'b0, 12'(11), 32'hD000_0002};
    pixel_data_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("stall_pixel_ready", pixel_ready, 0);
      tick();
    end
    rand_ready = 1'b1;
    for (int i = 2; i < 20; i++) send(50 + 3 * i, 11, 32'hD000_0000 + 32'(i));
    drain();

    // Randomized stream, mostly contiguous, with row changes and the right edge.
    px = 0;
    py = 0;
    for (int n = 0; n < 300; n++) begin
      int r;
      r = int'($urandom % 16);
      if (r < 11)      px = (px + 1) % 4096;
      else if (r < 13) px = int'($urandom % 4096);
      else if (r < 14) px = 4088 + int'($urandom % 8);
      else             py = int'($urandom % 4);
      send(px, py, $urandom);
      if ($urandom % 4 == 0) repeat ($urandom_range(1, 3)) tick();
    end
    drain();
    repeat (3) tick();
    chk("model_leftover", {32'(exp_q.size()), 32'(cur_len)}, 0);
    mon_en = 1'b0;
    rand_ready = 1'b0;
    tick();
    span_ready = 1'b1;

    // Lone pixel left idle.
    send(500, 9, 32'hE000_0001);
    seen = 1'b0;
`ifdef PIXEL_COALESCER_TIMEOUT_EN
    for (int k = 0; k < TIMEOUT + 1; k++) begin
      @(negedge clock);
      if (span_valid) seen = 1'b1;
    end
    chk("timeout_not_early", seen, 0);
    @(negedge clock);
    chk("timeout_span", {span_valid, span_x, span_length}, {1'b1, 12'd500, 5'd1});
`else
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (span_valid) seen = 1'b1;
    end
    chk("no_timeout_flush", seen, 0);
    tick();
    flush = 1'b1;
    @(negedge clock);
    chk("lone_flush_pixel_ready", pixel_ready, 0);
    tick();
    flush = 1'b0;
    @(negedge clock);
    chk("lone_flush_span", {span_valid, span_x, span_length}, {1'b1, 12'd500, 5'd1});
`endif
    tick();
    tick();

    // Flush with a partial span of 5 while the consumer is stalled.
    for (int i = 0; i < 5; i++) send(200 + i, 2, 32'hF000_0000 + 32'(i));
    span_ready = 1'b0;
    flush = 1'b1;
    pixel_data = {4'b0, 12'(205), 4'b0, 12'(2), 32'hF000_0005};
    pixel_data_valid = 1'b1;
    @(negedge clock);
    chk("flush_pixel_ready", pixel_ready, 0);
    chk("flush_pre_state", {span_valid, idle}, 0);
    tick();
    @(negedge clock);
    chk("flush_span", {span_valid, span_x, span_y, span_length, idle},
        {1'b1, 12'd200, 12'd2, 5'd5, 1'b0});
    chk_data("flush_span_data", span_data, d_f);
    tick();
    @(negedge clock);
    chk("flush_held", {span_valid, idle}, 2'b10);
    tick();
    span_ready = 1'b1;
    @(negedge clock);
    chk("flush_taken_valid", span_valid, 1);
    tick();
    flush = 1'b0;
    pixel_data_valid = 1'b0;
    @(negedge clock);
    chk("flush_idle_after", {span_valid, idle}, 2'b01);

    // Reset with both an output span and an open accumulator.
    tick();
    span_ready = 1'b0;
    send(300, 4, 32'h3000_0000);
    send(301, 4, 32'h3000_0001);
    send(310, 4, 32'h3000_0002);
    send(311, 4, 32'h3000_0003);
    @(negedge clock);
    chk("pre_reset_busy", {span_valid, idle}, 2'b10);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    span_ready = 1'b1;
    @(negedge clock);
    chk("mid_reset_state", {span_valid, idle, span_x, span_length}, {1'b0, 1'b1, 12'd0, 5'd0});
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (span_valid || !idle) seen = 1'b1;
    end
    chk("reset_nothing_emitted", seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
